// File: rtl/rob_pkg.sv
// Shared types and default sizes for the circular reorder buffer.
// Optional same-cycle CDB-to-lookup bypass: ROB_CDB_BYPASS_EN.
package rob_pkg;

  localparam int ROB_DEPTH  = 32;
  localparam int ROB_TAG_W  = 5;
  localparam int ROB_DATA_W = 32;
  localparam int ROB_REG_W  = 5;

  typedef enum logic [1:0] {
    IT_REG = 2'b00,
    IT_BR  = 2'b01,
    IT_ST  = 2'b10,
    IT_NOP = 2'b11
  } inst_type_e;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic [ROB_REG_W-1:0]  rd_reg;
    logic [ROB_DATA_W-1:0] pc;
    inst_type_e            inst_type;
    logic [ROB_DATA_W-1:0] data;
    logic                  taken;
  } rob_entry_t;

endpackage

// File: rtl/rob_circ_ptr.sv
// Head/tail/count pointer unit for the circular ROB.
// Flush has priority and returns all pointers to zero.
module rob_circ_ptr #(
  parameter int DEPTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  output logic [TAG_W-1:0] head,
  output logic [TAG_W-1:0] tail,
  output logic [TAG_W:0]   count,
  output logic             full,
  output logic             empty
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == (TAG_W+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/rob_circ.sv
// Circular reorder buffer: in-order dispatch/retire, OoO CDB completion.
// Define ROB_CDB_BYPASS_EN to forward same-cycle CDB data to lookups.
module rob_circ
  import rob_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int TAG_W  = ROB_TAG_W,
  parameter int DATA_W = ROB_DATA_W,
  parameter int REG_W  = ROB_REG_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dispatch_valid,
  output logic              dispatch_ready,
  output logic [TAG_W-1:0]  dispatch_tag,
  input  logic [REG_W-1:0]  dispatch_rd_reg,
  input  logic [DATA_W-1:0] dispatch_pc,
  input  logic [1:0]        dispatch_inst_type,
  input  logic [TAG_W-1:0]  rs_tag,
  input  logic [TAG_W-1:0]  rt_tag,
  input  logic              rs_ren,
  input  logic              rt_ren,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_data_valid,
  output logic              rt_data_valid,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_branch_taken,
  output logic              retire_valid,
  input  logic              retire_ready,
  output logic [TAG_W-1:0]  retire_tag,
  output logic [REG_W-1:0]  retire_rd_reg,
  output logic [DATA_W-1:0] retire_data,
  output logic [DATA_W-1:0] retire_pc,
  output logic [1:0]        retire_inst_type,
  output logic              retire_branch_taken,
  output logic              flush_flag,
  output logic [TAG_W:0]    rob_count
);

  typedef struct packed {
    logic [REG_W-1:0]  rd_reg;
    logic [DATA_W-1:0] pc;
    logic [1:0]        inst_type;
    logic [DATA_W-1:0] data;
    logic              taken;
  } slot_t;

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] done_q;
  slot_t            slot_q [DEPTH];

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;
  logic             full;
  logic             empty;

  slot_t head_slot;
  logic  disp_fire;
  logic  cdb_hit;
  logic  ret_fire;
  logic  flush_pend;
  logic  flush_fire;
  logic  rs_byp;
  logic  rt_byp;

  rob_circ_ptr #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_ptr (
    .clock (clock),
    .reset (reset),
    .push  (disp_fire),
    .pop   (ret_fire),
    .flush (flush_fire),
    .head  (head),
    .tail  (tail),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign head_slot    = slot_q[head];
  assign retire_valid = !empty && valid_q[head] && done_q[head];
  assign flush_pend   = retire_valid
                      && head_slot.inst_type == IT_BR
                      && head_slot.taken;
  assign ret_fire     = retire_valid && retire_ready;
  assign flush_fire   = flush_pend && retire_ready;

  assign dispatch_ready = !full && !flush_pend;
  assign dispatch_tag   = tail;
  assign disp_fire      = dispatch_valid && dispatch_ready;

  // A completion racing a flush belongs to a squashed entry.
  assign cdb_hit = cdb_valid && valid_q[cdb_tag] && !flush_fire;

`ifdef ROB_CDB_BYPASS_EN
  assign rs_byp = cdb_valid && (cdb_tag == rs_tag);
  assign rt_byp = cdb_valid && (cdb_tag == rt_tag);
`else
  assign rs_byp = 1'b0;
  assign rt_byp = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      done_q  <= '0;
    end else if (flush_fire) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (cdb_hit) done_q[cdb_tag] <= 1'b1;
      if (disp_fire) begin
        valid_q[tail] <= 1'b1;
        done_q[tail]  <= (dispatch_inst_type == IT_NOP);
      end
      if (ret_fire) valid_q[head] <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (disp_fire) begin
      slot_q[tail] <= '{
        rd_reg:    dispatch_rd_reg,
        pc:        dispatch_pc,
        inst_type: dispatch_inst_type,
        data:      '0,
        taken:     1'b0
      };
    end
    if (cdb_hit) begin
      slot_q[cdb_tag].data  <= cdb_data;
      slot_q[cdb_tag].taken <= cdb_branch_taken;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rs_data       <= '0;
      rs_data_valid <= 1'b0;
      rt_data       <= '0;
      rt_data_valid <= 1'b0;
      flush_flag    <= 1'b0;
    end else begin
      flush_flag <= flush_fire;
      if (rs_ren) begin
        if (rs_byp) begin
          rs_data       <= cdb_data;
          rs_data_valid <= 1'b1;
        end else begin
          rs_data       <= slot_q[rs_tag].data;
          rs_data_valid <= valid_q[rs_tag] && done_q[rs_tag];
        end
      end
      if (rt_ren) begin
        if (rt_byp) begin
          rt_data       <= cdb_data;
          rt_data_valid <= 1'b1;
        end else begin
          rt_data       <= slot_q[rt_tag].data;
          rt_data_valid <= valid_q[rt_tag] && done_q[rt_tag];
        end
      end
    end
  end

  assign retire_tag          = head;
  assign retire_rd_reg       = head_slot.rd_reg;
  assign retire_data         = head_slot.data;
  assign retire_pc           = head_slot.pc;
  assign retire_inst_type    = head_slot.inst_type;
  assign retire_branch_taken = head_slot.taken;
  assign rob_count           = count;

endmodule
